// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dmem_arbiter : two-master data-memory arbiter (round-robin / fixed priority
// with starvation guard). Optional: DMEM_ARB_MISALIGN_CHK_EN. Rev 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [1:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [1:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESP0 = 2'd1,
        S_RESP1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic [3:0]  r_wcnt0;
    logic [3:0]  r_wcnt1;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any;
    logic        w_force0;
    logic        w_force1;
    logic [1:0]  w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misalign;

    assign w_force0 = (r_wcnt0 >= c_max_wait);
    assign w_force1 = (r_wcnt1 >= c_max_wait);

    // Grants are held off while reset is asserted so nothing reaches memory.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_req && !m1_req) begin
                w_gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                w_gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (w_force0)             w_gnt0 = 1'b1;
                else if (w_force1)        w_gnt1 = 1'b1;
                else if (FIXED_PRIO != 0) w_gnt0 = 1'b1;
                else if (r_ptr)           w_gnt1 = 1'b1;
                else                      w_gnt0 = 1'b1;
            end
        end
    end

    assign w_any       = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    assign w_misalign = w_any &&
                        (((w_sel_we == 2'b10) && w_sel_addr[0]) ||
                         ((w_sel_we == 2'b11) && (w_sel_addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign m0_gnt         = w_gnt0;
    assign m1_gnt         = w_gnt1;
    assign mem_addr       = w_any ? w_sel_addr  : 32'd0;
    assign mem_write_data = w_any ? w_sel_wdata : 32'd0;
    assign mem_write      = (w_any && !w_misalign) ? w_sel_we : 2'b00;
    assign mem_read       = w_any && !w_misalign && (w_sel_we == 2'b00);

    // Responses never stall, so the next state depends only on this cycle's grant.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (mem_read) begin
            w_state_nxt = w_gnt1 ? S_RESP1 : S_RESP0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 1'b0;
            r_wcnt0    <= 4'd0;
            r_wcnt1    <= 4'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            if (w_gnt0)      r_ptr <= 1'b1;
            else if (w_gnt1) r_ptr <= 1'b0;

            if (m0_req && !w_gnt0)
                r_wcnt0 <= (r_wcnt0 == 4'hF) ? 4'hF : r_wcnt0 + 4'd1;
            else
                r_wcnt0 <= 4'd0;

            if (m1_req && !w_gnt1)
                r_wcnt1 <= (r_wcnt1 == 4'hF) ? 4'hF : r_wcnt1 + 4'd1;
            else
                r_wcnt1 <= 4'd0;

            if (mem_read && w_gnt0) r_m0_rdata <= mem_read_data;
            if (mem_read && w_gnt1) r_m1_rdata <= mem_read_data;
        end
    end

    assign m0_rvalid = (r_state == S_RESP0);
    assign m1_rvalid = (r_state == S_RESP1);
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    logic r_m0_err;
    logic r_m1_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
        end else begin
            r_m0_err <= w_gnt0 && w_misalign;
            r_m1_err <= w_gnt1 && w_misalign;
        end
    end

    assign m0_err = r_m0_err;
    assign m1_err = r_m1_err;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between requesters; 1 = m0 always wins.
REQ-002 Parameter MAX_WAIT, default 4: 1..15; consecutive lost arbitrations after which a waiting requester is forced to win.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mN_req  input  1  requester N (N=0 pipeline MEM stage, N=1 DMA/debug) access request; held until granted.
REQ-006 mN_we  input  2  write type: 00 read, 01 byte, 10 half, 11 word (data_memory mem_write encoding).
REQ-007 mN_addr  input  32  byte address; mN_wdata  input  32  write data.
REQ-008 mN_gnt  output  1  combinational; access accepted this cycle.
REQ-009 mN_rvalid  output  1  registered read-return strobe.
REQ-010 mN_rdata  output  32  registered read data, valid with mN_rvalid.
REQ-011 mN_err  output  1  registered error strobe, active only with DMEM_ARB_MISALIGN_CHK_EN.
REQ-012 mem_addr, mem_write_data  output  32 each  driven from the granted requester, else 0.
REQ-013 mem_write  output  2  granted mN_we if granted, else 00.
REQ-014 mem_read  output  1  high when granted access is a read (we=00).
REQ-015 mem_read_data  input  32  combinational memory read data.

Function
REQ-016 At most one gnt SHALL be high per cycle; a request SHALL be granted in the cycle it is asserted if it wins; no idle bubble between back-to-back grants.
REQ-017 Round-robin: pointer SHALL name the preferred requester; on a grant to N the pointer SHALL move to the other requester; a sole requester always wins regardless of the pointer.
REQ-018 Wait counters: wcntN SHALL increment (saturating at 15) each cycle mN_req=1 and mN_gnt=0, and clear on grant or when req drops.
REQ-019 When wcntN >= MAX_WAIT, requester N SHALL win over the pointer and over FIXED_PRIO; if both reach MAX_WAIT, m0 wins.
REQ-020 Read latency: granted read in cycle T SHALL give rdata = mem_read_data sampled at end of T and rvalid=1 for exactly cycle T+1, routed only to the granted requester.
REQ-021 Writes SHALL complete in the grant cycle; no rvalid for writes.
REQ-022 Write followed by read of the same word in the next grant SHALL return the new data (memory writes at the T edge).
REQ-023 Outstanding-response state machine: IDLE (no response pending) -> RESP0/RESP1 on a read grant to m0/m1; RESPx -> RESPy/IDLE each cycle per that cycle's grant; no stalling for response.
REQ-024 Requester dropping req without gnt SHALL cancel with no memory side effect.

Reset
REQ-025 rst_n low SHALL immediately force: pointer to m0, wcnt0/wcnt1=0, state IDLE, rvalid/err=0, rdata=0.
REQ-026 During reset all gnt=0, mem_write=00, mem_read=0, mem_addr/mem_write_data=0.
REQ-027 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.

Configuration
REQ-028 Macro DMEM_ARB_MISALIGN_CHK_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=00 SHALL still be granted but drive mem_write=00, mem_read=0, and pulse mN_err (no rvalid) in T+1.
REQ-029 Macro undefined: no check; mN_err tied 0; misaligned accesses pass to memory unchanged.

Verification
REQ-030 Both req every cycle, FIXED_PRIO=0: gnt alternates m0,m1,m0,... from reset; each rvalid one cycle after its gnt.
REQ-031 FIXED_PRIO=1, MAX_WAIT=4, both req continuously: m0 wins 4 cycles, m1 wins 5th, repeat.
REQ-032 m1 writes word 0xDEADBEEF to 0x40, m0 reads 0x40 next cycle: m0_rvalid=1, m0_rdata=0xDEADBEEF.
REQ-033 rst_n low for one cycle in mid-read stream: outputs 0 immediately; after release first gnt to m0 and no stale rvalid.
REQ-034 With macro: m0 word write addr 0x42 -> mem_write=00, m0_err=1 next cycle; without macro -> mem_write=11, m0_err=0.
